// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame size and baud divisor helper.
// Used by both the transmitter and the receiver so the two ends agree on framing.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Truncating divide: the mid-bit sampling margin absorbs the rounding error.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus one history flop
// for falling-edge detection of the start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_serial,
   output logic rx_sync,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // NOTE: these flops reset to 1 (idle line) so leaving reset never fakes a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_serial;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_sync = sync_q;
   assign fall    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: glitch-filtered start detection, mid-bit sampling, and a
// valid/ready byte handoff with framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_serial,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_divisor
         $error("uart_rx: CLKS_PER_BIT=%0d is below 4", CLKS_PER_BIT);
      end
   endgenerate

   logic rx_sync;
   logic fall;

   uart_rx_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .rx_sync   (rx_sync),
      .fall      (fall)
   );

   uart_state_e          state_q,     state_d;
   logic [CNT_W-1:0]     clk_cnt_q,   clk_cnt_d;
   logic [2:0]           bit_idx_q,   bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q,     shreg_d;
   logic [DATA_BITS-1:0] data_q,      data_d;
   logic                 valid_q,     valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q,   overrun_d;

   // NOTE: every flop uses <= so all registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      // Host handshake; a byte completing this same cycle re-asserts valid below.
      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            if (fall) begin
               state_d = START;
            end
         end

         START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               if (!rx_sync) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shreg_d   = {rx_sync, shreg_q[DATA_BITS-1:1]};
               if (bit_idx_q == LAST_IDX) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               state_d   = IDLE;
               if (rx_sync) begin
                  overrun_d = valid_q && !rx_ready;
                  data_d    = shreg_q;
                  valid_d   = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_busy      = (state_q != IDLE);
   assign rx_frame_err = frame_err_q;
   assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged 8N1 frames, a frame-level timing
// model compared against the DUT every cycle, plus literal per-scenario checks.
module tb_uart_rx;

   localparam int CPB = 434;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB;

   logic       clk;
   logic       rst;
   logic       rx_serial;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;

   uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_serial    (rx_serial),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      longint     due;
   } frame_t;

   frame_t     exp_q[$];
   longint     cyc       = 0;
   longint     busy_from = 1;
   longint     busy_to   = 0;
   longint     last_due  = 0;
   logic       val_e     = 1'b0;
   logic [7:0] data_e    = '0;
   logic       ferr_e    = 1'b0;
   logic       ovr_e     = 1'b0;
   logic       busy_e;

   logic [7:0] captured[$];
   int         ferr_cnt;
   int         ovr_cnt;
   int         busy_cnt;

   // Frame-level model: a completed frame takes effect exactly LAT cycles after its start edge.
   always @(posedge clk) begin
      frame_t f;
      logic   new_byte;
      cyc++;
      if (rst) begin
         exp_q.delete();
         val_e     = 1'b0;
         data_e    = '0;
         ferr_e    = 1'b0;
         ovr_e     = 1'b0;
         busy_from = 1;
         busy_to   = 0;
      end else begin
         if (rx_valid && rx_ready) captured.push_back(rx_data);
         if (rx_frame_err) ferr_cnt++;
         if (rx_overrun) ovr_cnt++;
         if (rx_busy) busy_cnt++;
         ferr_e   = 1'b0;
         ovr_e    = 1'b0;
         new_byte = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            f = exp_q.pop_front();
            if (f.stop) begin
               ovr_e    = val_e && !rx_ready;
               val_e    = 1'b1;
               data_e   = f.data;
               new_byte = 1'b1;
            end else begin
               ferr_e = 1'b1;
            end
         end
         if (!new_byte && val_e && rx_ready) val_e = 1'b0;
      end
      #1;
      busy_e = (cyc >= busy_from) && (cyc <= busy_to);
      check("outputs", {rx_busy, rx_valid, rx_data, rx_frame_err, rx_overrun},
                       {busy_e, val_e, data_e, ferr_e, ovr_e});
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_stats();
      captured.delete();
      ferr_cnt = 0;
      ovr_cnt  = 0;
      busy_cnt = 0;
   endtask

   // Called at a negedge; returns at a negedge with the stop level still on the line.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      longint start;
      frame_t f;
      start     = cyc + 1;
      f.data    = d;
      f.stop    = stop;
      f.due     = start + LAT;
      last_due  = f.due;
      exp_q.push_back(f);
      busy_from = start + 2;
      busy_to   = start + LAT - 1;
      rx_serial = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = d[i];
         idle(CPB);
      end
      rx_serial = stop;
      idle(CPB);
   endtask

   initial begin
      longint start;
      int     k;
      rst       = 1'b1;
      rx_serial = 1'b1;
      rx_ready  = 1'b0;
      ferr_cnt  = 0;
      ovr_cnt   = 0;
      busy_cnt  = 0;
      idle(5);
      rst = 1'b0;
      idle(5);
      check("reset_outputs", {rx_busy, rx_valid, rx_data, rx_frame_err, rx_overrun}, 32'h0);

      // Single byte, host always ready
      clear_stats();
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1);
      idle(300);
      check("t1_beats", captured.size(), 1);
      check("t1_data", captured.size() > 0 ? captured[0] : 8'h00, 8'hA5);
      check("t1_no_ferr", ferr_cnt, 0);
      check("t1_no_ovr", ovr_cnt, 0);

      // Back-to-back frames
      clear_stats();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      idle(300);
      check("t2_beats", captured.size(), 2);
      check("t2_data0", captured.size() > 0 ? captured[0] : 8'h00, 8'h3C);
      check("t2_data1", captured.size() > 1 ? captured[1] : 8'h00, 8'hC3);

      // Short low pulse: start bit rejected at its midpoint
      clear_stats();
      start     = cyc + 1;
      busy_from = start + 2;
      busy_to   = start + 1 + CPB / 2;
      rx_serial = 1'b0;
      idle(100);
      rx_serial = 1'b1;
      idle(600);
      check("t3_busy_le_220", (busy_cnt > 0) && (busy_cnt <= 220), 1);
      check("t3_no_beats", captured.size(), 0);
      check("t3_valid_low", rx_valid, 0);

      // Framing error, then line held low
      clear_stats();
      send_frame(8'h55, 1'b0);
      idle(1000);
      check("t4_ferr_pulses", ferr_cnt, 1);
      check("t4_valid_low", rx_valid, 0);
      check("t4_idle_on_low_line", rx_busy, 0);
      rx_serial = 1'b1;
      idle(CPB);

      // Overrun with host stalled, then same-cycle accept plus new byte
      clear_stats();
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(50);
      check("t5_ovr_pulses", ovr_cnt, 1);
      check("t5_data", rx_data, 8'h22);
      check("t5_valid_held", rx_valid, 1);
      fork
         send_frame(8'h33, 1'b1);
         begin
            @(negedge clk);
            k = 0;
            while (cyc != last_due - 1 && k < 6000) begin
               @(negedge clk);
               k++;
            end
            check("t5_accept_slot_reached", cyc == last_due - 1, 1);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      idle(20);
      check("t5_data_after_same_cycle", rx_data, 8'h33);
      check("t5_valid_after_same_cycle", rx_valid, 1);
      check("t5_no_new_ovr", ovr_cnt, 1);
      check("t5_accepted_22", captured.size() > 0 ? captured[0] : 8'h00, 8'h22);

      // Reset during data bit 3, then a clean frame
      start     = cyc + 1;
      busy_from = start + 2;
      busy_to   = start + 1_000_000;
      rx_serial = 1'b0;
      idle(4 * CPB + 200);
      check("t6_busy_mid_frame", rx_busy, 1);
      #3 rst = 1'b1;
      #1 check("t6_async_reset_outputs",
               {rx_busy, rx_valid, rx_data, rx_frame_err, rx_overrun}, 32'h0);
      rx_serial = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(100);
      clear_stats();
      rx_ready = 1'b1;
      send_frame(8'h81, 1'b1);
      idle(300);
      check("t6_beats", captured.size(), 1);
      check("t6_data", captured.size() > 0 ? captured[0] : 8'h00, 8'h81);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
